// File: rtl/arm_pkg.sv
// Shared encodings for the ARM-subset ID/EX control core: ALU opcodes,
// condition codes, addressing modes, decoded control bundle and condition evaluation.
package arm_pkg;

    localparam int unsigned OP_W   = 4;
    localparam int unsigned AM_W   = 2;
    localparam int unsigned FLAG_W = 4;

    localparam logic [OP_W-1:0] ALU_AND = 4'h0;
    localparam logic [OP_W-1:0] ALU_EOR = 4'h1;
    localparam logic [OP_W-1:0] ALU_SUB = 4'h2;
    localparam logic [OP_W-1:0] ALU_RSB = 4'h3;
    localparam logic [OP_W-1:0] ALU_ADD = 4'h4;
    localparam logic [OP_W-1:0] ALU_ADC = 4'h5;
    localparam logic [OP_W-1:0] ALU_SBC = 4'h6;
    localparam logic [OP_W-1:0] ALU_RSC = 4'h7;
    localparam logic [OP_W-1:0] ALU_TST = 4'h8;
    localparam logic [OP_W-1:0] ALU_TEQ = 4'h9;
    localparam logic [OP_W-1:0] ALU_CMP = 4'hA;
    localparam logic [OP_W-1:0] ALU_CMN = 4'hB;
    localparam logic [OP_W-1:0] ALU_ORR = 4'hC;
    localparam logic [OP_W-1:0] ALU_MOV = 4'hD;
    localparam logic [OP_W-1:0] ALU_BIC = 4'hE;
    localparam logic [OP_W-1:0] ALU_MVN = 4'hF;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;

    localparam logic [AM_W-1:0] AM_ROT_IMM   = 2'b00;
    localparam logic [AM_W-1:0] AM_REG       = 2'b01;
    localparam logic [AM_W-1:0] AM_IMM12     = 2'b10;
    localparam logic [AM_W-1:0] AM_SHIFT_REG = 2'b11;

    typedef struct packed {
        logic [OP_W-1:0] alu_op;
        logic            load;
        logic            mem_write;
        logic [AM_W-1:0] am;
        logic            store_cc;
        logic            b;
        logic            bl;
        logic            mem_size;
        logic            mem_e;
        logic            rf_e;
    } id_ctrl_t;

    // Flags are ordered {N,Z,C,V}; the reserved code 1111 never passes.
    function automatic logic cond_pass(input logic [3:0] cond, input logic [FLAG_W-1:0] f);
        logic n, z, c, v;
        {n, z, c, v} = f;
        case (cond)
            COND_EQ: cond_pass = z;
            COND_NE: cond_pass = !z;
            COND_CS: cond_pass = c;
            COND_CC: cond_pass = !c;
            COND_MI: cond_pass = n;
            COND_PL: cond_pass = !n;
            COND_VS: cond_pass = v;
            COND_VC: cond_pass = !v;
            COND_HI: cond_pass = c && !z;
            COND_LS: cond_pass = !c || z;
            COND_GE: cond_pass = (n == v);
            COND_LT: cond_pass = (n != v);
            COND_GT: cond_pass = !z && (n == v);
            COND_LE: cond_pass = z || (n != v);
            COND_AL: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/arm_alu.sv
// Combinational ARM data-processing ALU: shared adder for arithmetic ops,
// bitwise mux for logical ops, N/Z/C/V generation.
module arm_alu
    import arm_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [OP_W-1:0]   op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic              c_in_i,
    input  logic              shifter_c_i,
    output logic [DATA_W-1:0] result_o,
    output logic              n_o,
    output logic              z_o,
    output logic              c_o,
    output logic              v_o,
    output logic              logical_o
);

    logic [DATA_W-1:0] add_x;
    logic [DATA_W-1:0] add_y;
    logic              add_cin;
    logic [DATA_W:0]   sum;

    // Subtraction is x + ~y + cin so carry-out is directly NOT borrow.
    always_comb begin
        add_x     = a_i;
        add_y     = b_i;
        add_cin   = 1'b0;
        logical_o = 1'b0;
        case (op_i)
            ALU_SUB, ALU_CMP: begin add_x = a_i; add_y = ~b_i; add_cin = 1'b1;   end
            ALU_RSB:          begin add_x = b_i; add_y = ~a_i; add_cin = 1'b1;   end
            ALU_ADD, ALU_CMN: begin add_x = a_i; add_y = b_i;  add_cin = 1'b0;   end
            ALU_ADC:          begin add_x = a_i; add_y = b_i;  add_cin = c_in_i; end
            ALU_SBC:          begin add_x = a_i; add_y = ~b_i; add_cin = c_in_i; end
            ALU_RSC:          begin add_x = b_i; add_y = ~a_i; add_cin = c_in_i; end
            default:          logical_o = 1'b1;
        endcase
    end

    assign sum = {1'b0, add_x} + {1'b0, add_y} + (DATA_W+1)'(add_cin);

    always_comb begin
        result_o = sum[DATA_W-1:0];
        case (op_i)
            ALU_AND, ALU_TST: result_o = a_i & b_i;
            ALU_EOR, ALU_TEQ: result_o = a_i ^ b_i;
            ALU_ORR:          result_o = a_i | b_i;
            ALU_MOV:          result_o = b_i;
            ALU_BIC:          result_o = a_i & ~b_i;
            ALU_MVN:          result_o = ~b_i;
            default:          result_o = sum[DATA_W-1:0];
        endcase
    end

    assign n_o = result_o[DATA_W-1];
    assign z_o = (result_o == '0);
    assign c_o = logical_o ? shifter_c_i : sum[DATA_W];
    assign v_o = logical_o ? 1'b0
               : ((add_x[DATA_W-1] == add_y[DATA_W-1]) && (sum[DATA_W-1] != add_x[DATA_W-1]));

endmodule

// File: rtl/arm_decode_alu_cond.sv
// Combined ID/EX control core: instruction decode, EX-stage ALU with PSR flag
// register, and forwarded condition evaluation for branch decisions.
module arm_decode_alu_cond
    import arm_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         id_instr,
    output logic [OP_W-1:0]     id_alu_op,
    output logic                id_load,
    output logic                id_mem_write,
    output logic [AM_W-1:0]     id_am,
    output logic                id_store_cc,
    output logic                id_b,
    output logic                id_bl,
    output logic                id_mem_size,
    output logic                id_mem_e,
    output logic                id_rf_e,
    input  logic [OP_W-1:0]     ex_alu_op,
    input  logic [DATA_W-1:0]   ex_a,
    input  logic [DATA_W-1:0]   ex_b,
    input  logic                ex_shifter_c,
    input  logic                ex_store_cc,
    output logic [DATA_W-1:0]   alu_result,
    output logic                alu_n,
    output logic                alu_z,
    output logic                alu_c,
    output logic                alu_v,
    output logic [FLAG_W-1:0]   flags,
    output logic                cond_true,
    output logic                branch,
    output logic                branch_link
);

    logic [FLAG_W-1:0] flags_q;
    logic [FLAG_W-1:0] flags_d;
    logic              alu_logical;
    id_ctrl_t          ctrl;
    logic              unused_instr_bits;

    arm_alu #(.DATA_W(DATA_W)) u_alu (
        .op_i        (ex_alu_op),
        .a_i         (ex_a),
        .b_i         (ex_b),
        .c_in_i      (flags_q[1]),
        .shifter_c_i (ex_shifter_c),
        .result_o    (alu_result),
        .n_o         (alu_n),
        .z_o         (alu_z),
        .c_o         (alu_c),
        .v_o         (alu_v),
        .logical_o   (alu_logical)
    );

    // Logical ops leave V untouched.
    always_comb begin
        flags_d = flags_q;
        if (ex_store_cc) begin
            flags_d = {alu_n, alu_z, alu_c, alu_logical ? flags_q[0] : alu_v};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            flags_q <= '0;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign flags = flags_q;

    // flags_d already equals flags_q when no update is pending, giving forwarding for free.
    assign cond_true   = cond_pass(id_instr[31:28], flags_d);
    assign branch      = id_b & cond_true;
    assign branch_link = id_bl & cond_true;

    always_comb begin
        ctrl = '0;
        if (id_instr != 32'h0) begin
            if (id_instr[27:26] == 2'b00) begin
                ctrl.alu_op   = id_instr[24:21];
                ctrl.store_cc = id_instr[20];
                ctrl.rf_e     = (id_instr[24:23] != 2'b10);
                if (id_instr[25])                 ctrl.am = AM_ROT_IMM;
                else if (id_instr[11:4] == 8'h0)  ctrl.am = AM_REG;
                else                              ctrl.am = AM_SHIFT_REG;
            end else if (id_instr[27:26] == 2'b01) begin
                ctrl.load      = id_instr[20];
                ctrl.mem_write = ~id_instr[20];
                ctrl.mem_e     = 1'b1;
                ctrl.mem_size  = id_instr[22];
                ctrl.rf_e      = id_instr[20];
                ctrl.alu_op    = id_instr[23] ? ALU_ADD : ALU_SUB;
                if (!id_instr[25])                ctrl.am = AM_IMM12;
                else if (id_instr[11:4] == 8'h0)  ctrl.am = AM_REG;
                else                              ctrl.am = AM_SHIFT_REG;
            end else if (id_instr[27:25] == 3'b101) begin
                ctrl.b      = 1'b1;
                ctrl.bl     = id_instr[24];
                ctrl.rf_e   = id_instr[24];
                ctrl.alu_op = ALU_ADD;
                ctrl.am     = AM_ROT_IMM;
            end
        end
    end

    assign id_alu_op    = ctrl.alu_op;
    assign id_load      = ctrl.load;
    assign id_mem_write = ctrl.mem_write;
    assign id_am        = ctrl.am;
    assign id_store_cc  = ctrl.store_cc;
    assign id_b         = ctrl.b;
    assign id_bl        = ctrl.bl;
    assign id_mem_size  = ctrl.mem_size;
    assign id_mem_e     = ctrl.mem_e;
    assign id_rf_e      = ctrl.rf_e;

    assign unused_instr_bits = ^{id_instr[19:12], id_instr[3:0]};

endmodule

// File: tb/tb_arm_decode_alu_cond.sv
// Directed bench for arm_decode_alu_cond: ALU flags, flag register,
// forwarding into condition evaluation, and decode of representative encodings.
module tb_arm_decode_alu_cond;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] id_instr;
    logic [3:0]  id_alu_op;
    logic        id_load, id_mem_write, id_store_cc, id_b, id_bl;
    logic        id_mem_size, id_mem_e, id_rf_e;
    logic [1:0]  id_am;
    logic [3:0]  ex_alu_op;
    logic [31:0] ex_a, ex_b;
    logic        ex_shifter_c, ex_store_cc;
    logic [31:0] alu_result;
    logic        alu_n, alu_z, alu_c, alu_v;
    logic [3:0]  flags;
    logic        cond_true, branch, branch_link;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    arm_decode_alu_cond #(.DATA_W(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .id_instr     (id_instr),
        .id_alu_op    (id_alu_op),
        .id_load      (id_load),
        .id_mem_write (id_mem_write),
        .id_am        (id_am),
        .id_store_cc  (id_store_cc),
        .id_b         (id_b),
        .id_bl        (id_bl),
        .id_mem_size  (id_mem_size),
        .id_mem_e     (id_mem_e),
        .id_rf_e      (id_rf_e),
        .ex_alu_op    (ex_alu_op),
        .ex_a         (ex_a),
        .ex_b         (ex_b),
        .ex_shifter_c (ex_shifter_c),
        .ex_store_cc  (ex_store_cc),
        .alu_result   (alu_result),
        .alu_n        (alu_n),
        .alu_z        (alu_z),
        .alu_c        (alu_c),
        .alu_v        (alu_v),
        .flags        (flags),
        .cond_true    (cond_true),
        .branch       (branch),
        .branch_link  (branch_link)
    );

    // Decode outputs packed {alu_op, load, mem_write, am, store_cc, b, bl, mem_size, mem_e, rf_e}
    logic [13:0] dec;
    assign dec = {id_alu_op, id_load, id_mem_write, id_am, id_store_cc,
                  id_b, id_bl, id_mem_size, id_mem_e, id_rf_e};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alu_drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic sc, input logic shc);
        ex_alu_op    = op;
        ex_a         = a;
        ex_b         = b;
        ex_store_cc  = sc;
        ex_shifter_c = shc;
        #1;
    endtask

    initial begin
        reset = 1'b0;
        id_instr = 32'h0;
        alu_drive(4'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        check("reset_flags", 32'(flags), 32'h0);
        reset = 1'b1;
        repeat (3) tick();
        check("hold_flags", 32'(flags), 32'h0);

        // ADD signed overflow
        alu_drive(4'h4, 32'h7FFF_FFFF, 32'h1, 1'b1, 1'b0);
        check("add_ovf_res", alu_result, 32'h8000_0000);
        check("add_ovf_nzcv", 32'({alu_n, alu_z, alu_c, alu_v}), 32'h9);
        tick();
        check("add_ovf_flags", 32'(flags), 32'h9);

        // CMP equal with BEQ in ID the same cycle; registered Z is still 0
        alu_drive(4'hA, 32'd5, 32'd5, 1'b1, 1'b0);
        id_instr = 32'h0A00_0004;
        #1;
        check("cmp_nzcv", 32'({alu_n, alu_z, alu_c, alu_v}), 32'h6);
        check("beq_fwd", 32'({cond_true, branch, branch_link}), 32'h6);
        tick();
        check("cmp_flags", 32'(flags), 32'h6);

        // Same BEQ without an update uses registered Z=1; BNE then fails
        ex_store_cc = 1'b0;
        #1;
        check("beq_reg", 32'({cond_true, branch}), 32'h3);
        id_instr = 32'h1A00_0004;
        #1;
        check("bne_reg", 32'({cond_true, branch}), 32'h0);

        // ADC with C=1
        alu_drive(4'h5, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0);
        check("adc_res", alu_result, 32'h0);
        check("adc_zc", 32'({alu_z, alu_c}), 32'h3);

        // Clear C via ADD 0+0, then SBC 3-1-!C = 1
        alu_drive(4'h4, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        check("clr_c_flags", 32'(flags), 32'h4);
        alu_drive(4'h6, 32'd3, 32'd1, 1'b0, 1'b0);
        check("sbc_res", alu_result, 32'h1);
        check("sbc_c", 32'(alu_c), 32'h1);

        // RSB 1-3 borrows: -2, N=1 C=0
        alu_drive(4'h3, 32'd3, 32'd1, 1'b0, 1'b0);
        check("rsb_res", alu_result, 32'hFFFF_FFFE);
        check("rsb_nc", 32'({alu_n, alu_c}), 32'h2);

        // Logical op preserves V: set V via overflow, then MOVS #0 with shifter carry
        alu_drive(4'h4, 32'h7FFF_FFFF, 32'h1, 1'b1, 1'b0);
        tick();
        alu_drive(4'hD, 32'h1234_5678, 32'h0, 1'b1, 1'b1);
        check("mov_nzcv", 32'({alu_n, alu_z, alu_c, alu_v}), 32'h6);
        id_instr = 32'h6000_0000;
        #1;
        check("bvs_fwd_logical", 32'(cond_true), 32'h1);
        tick();
        check("mov_flags", 32'(flags), 32'h7);

        // BIC / MVN results
        alu_drive(4'hE, 32'hFF00_FF00, 32'h0F0F_0F0F, 1'b0, 1'b0);
        check("bic_res", alu_result, 32'hF000_F000);
        alu_drive(4'hF, 32'h0, 32'h0000_00FF, 1'b0, 1'b0);
        check("mvn_res", alu_result, 32'hFFFF_FF00);

        // Decode table
        id_instr = 32'hE5D1_2004;
        #1;
        check("dec_ldrb", 32'(dec), 32'(14'b0100_1_0_10_0_0_0_1_1_1));
        id_instr = 32'hE292_1001;
        #1;
        check("dec_adds", 32'(dec), 32'(14'b0100_0_0_00_1_0_0_0_0_1));
        id_instr = 32'h0000_0000;
        #1;
        check("dec_nop", 32'(dec), 32'h0);
        id_instr = 32'hE151_0002;
        #1;
        check("dec_cmp_reg", 32'(dec), 32'(14'b1010_0_0_01_1_0_0_0_0_0));
        id_instr = 32'hE781_2103;
        #1;
        check("dec_str_shreg", 32'(dec), 32'(14'b0100_0_1_11_0_0_0_0_1_0));
        id_instr = 32'hEB00_0010;
        #1;
        check("dec_bl", 32'(dec), 32'(14'b0100_0_0_00_0_1_1_0_0_1));
        check("bl_taken", 32'({cond_true, branch, branch_link}), 32'h7);
        id_instr = 32'hE800_0000;
        #1;
        check("dec_other", 32'(dec), 32'h0);

        // NV never passes; flags now 0111: GE (N==V) false, LT true, HI false
        id_instr = 32'hF000_0000;
        #1;
        check("cond_nv", 32'(cond_true), 32'h0);
        id_instr = 32'hAA00_0000;
        #1;
        check("cond_ge", 32'({cond_true, branch}), 32'h0);
        id_instr = 32'hBA00_0000;
        #1;
        check("cond_lt", 32'({cond_true, branch}), 32'h3);
        id_instr = 32'h8A00_0000;
        #1;
        check("cond_hi", 32'(cond_true), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
